// File: rtl/spi_mm_bridge.sv
// -----------------------------------------------------------------------------
// spi_mm_bridge
//   Mode 0, MSB-first SPI slave. Each host frame becomes one single-word access
//   on the memory-mapped master bus. All SPI pins are oversampled in clk_sys_i,
//   so there is no SCLK clock domain.
//
//   Frames:
//     write : CMD_WRITE, ADDR, DATA[15:8], DATA[7:0]
//     read  : CMD_READ,  ADDR, DUMMY, then 16 data bits out on MISO
//
// Ports:
//   clk_sys_i      system clock
//   rst_n_i        asynchronous active-low reset
//   spi_cs_n_i     chip select, active-low (asynchronous)
//   spi_sclk_i     SPI clock (asynchronous, oversampled)
//   spi_mosi_i     host-to-slave data
//   spi_miso_o     slave-to-host data, 0 outside the read data phase
//   spi_miso_oe_o  MISO output enable (tristate lives at the top level)
//   m_addr_o       bus address, updated when the address byte completes
//   m_wdata_o      bus write data, updated together with the m_we_o pulse
//   m_rdata_i      bus read data, valid 2 cycles after an address change
//   m_we_o         write strobe, one-cycle pulse
//   frame_err_o    one-cycle pulse on an invalid command or aborted frame
// -----------------------------------------------------------------------------
module spi_mm_bridge #(
    parameter int         MM_ADDR_WIDTH = 8,
    parameter int         MM_DATA_WIDTH = 16,
    parameter logic [7:0] CMD_WRITE     = 8'h02,
    parameter logic [7:0] CMD_READ      = 8'h03
) (
    input  logic                     clk_sys_i,
    input  logic                     rst_n_i,
    input  logic                     spi_cs_n_i,
    input  logic                     spi_sclk_i,
    input  logic                     spi_mosi_i,
    output logic                     spi_miso_o,
    output logic                     spi_miso_oe_o,
    output logic [MM_ADDR_WIDTH-1:0] m_addr_o,
    output logic [MM_DATA_WIDTH-1:0] m_wdata_o,
    input  logic [MM_DATA_WIDTH-1:0] m_rdata_i,
    output logic                     m_we_o,
    output logic                     frame_err_o
);

    localparam int               CNT_W         = $clog2(MM_DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BYTE_BIT = CNT_W'(7);
    localparam logic [CNT_W-1:0] LAST_WORD_BIT = CNT_W'(MM_DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, DONE, IGNORE
    } state_t;

    // ---------------- input synchronisers ----------------
    // Bit order in the chains: [2] = cs_n, [1] = sclk, [0] = mosi.
    // Everything resets to 0 so that CS already low at reset release never
    // looks like a falling edge.
    logic [2:0] async_in;
    logic [2:0] meta_reg;
    logic [2:0] sync_reg;
    logic       sclk_prev_reg;
    logic       cs_n_prev_reg;
    logic       armed_reg;      // cs_n has been seen high since reset

    assign async_in = {spi_cs_n_i, spi_sclk_i, spi_mosi_i};

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_reg      <= '0;
            sync_reg      <= '0;
            sclk_prev_reg <= 1'b0;
            cs_n_prev_reg <= 1'b0;
            armed_reg     <= 1'b0;
        end else begin
            meta_reg      <= async_in;
            sync_reg      <= meta_reg;
            sclk_prev_reg <= sync_reg[1];
            cs_n_prev_reg <= sync_reg[2];
            armed_reg     <= armed_reg | sync_reg[2];
        end
    end

    logic cs_n_sync;
    logic mosi_sync;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_fall;

    assign cs_n_sync = sync_reg[2];
    assign mosi_sync = sync_reg[0];
    assign sclk_rise = sync_reg[1] & ~sclk_prev_reg;
    assign sclk_fall = ~sync_reg[1] & sclk_prev_reg;
    assign cs_fall   = cs_n_prev_reg & ~cs_n_sync;

    // ---------------- frame state ----------------
    state_t                   state_reg,  state_next;
    logic [CNT_W-1:0]         bit_cnt_reg, bit_cnt_next;
    logic [MM_DATA_WIDTH-1:0] rx_reg,     rx_next;
    logic [MM_DATA_WIDTH-1:0] tx_reg,     tx_next;
    logic                     miso_reg,   miso_next;
    logic                     is_read_reg, is_read_next;
    logic [MM_ADDR_WIDTH-1:0] addr_reg,   addr_next;
    logic [MM_DATA_WIDTH-1:0] wdata_reg,  wdata_next;
    logic                     we_reg,     we_next;
    logic                     err_reg,    err_next;

    logic [MM_DATA_WIDTH-1:0] rx_shifted;
    logic [CNT_W-1:0]         bit_cnt_inc;

    assign rx_shifted  = {rx_reg[MM_DATA_WIDTH-2:0], mosi_sync};
    assign bit_cnt_inc = bit_cnt_reg + CNT_W'(1);

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            rx_reg      <= '0;
            tx_reg      <= '0;
            miso_reg    <= 1'b0;
            is_read_reg <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            we_reg      <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            rx_reg      <= rx_next;
            tx_reg      <= tx_next;
            miso_reg    <= miso_next;
            is_read_reg <= is_read_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            we_reg      <= we_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        rx_next      = rx_reg;
        tx_next      = tx_reg;
        miso_next    = miso_reg;
        is_read_next = is_read_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        we_next      = 1'b0;
        err_next     = 1'b0;

        if (state_reg != IDLE && cs_n_sync) begin
            // CS released: every state that still expects bits is an abort.
            state_next   = IDLE;
            bit_cnt_next = '0;
            err_next     = (state_reg != DONE) && (state_reg != IGNORE);
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cs_fall) begin
                        state_next   = CMD;
                        bit_cnt_next = '0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        rx_next      = rx_shifted;
                        bit_cnt_next = bit_cnt_inc;
                        if (bit_cnt_reg == LAST_BYTE_BIT) begin
                            bit_cnt_next = '0;
                            if (rx_shifted[7:0] == CMD_WRITE) begin
                                state_next   = ADDR;
                                is_read_next = 1'b0;
                            end else if (rx_shifted[7:0] == CMD_READ) begin
                                state_next   = ADDR;
                                is_read_next = 1'b1;
                            end else begin
                                state_next = IGNORE;
                                err_next   = 1'b1;
                            end
                        end
                    end
                end
                ADDR: begin
                    if (sclk_rise) begin
                        rx_next      = rx_shifted;
                        bit_cnt_next = bit_cnt_inc;
                        if (bit_cnt_reg == LAST_BYTE_BIT) begin
                            bit_cnt_next = '0;
                            addr_next    = rx_shifted[MM_ADDR_WIDTH-1:0];
                            state_next   = is_read_reg ? DUMMY : WDATA;
                        end
                    end
                end
                DUMMY: begin
                    // The bus has had the whole dummy byte to settle m_rdata_i.
                    if (sclk_rise) begin
                        bit_cnt_next = bit_cnt_inc;
                        if (bit_cnt_reg == LAST_BYTE_BIT) begin
                            bit_cnt_next = '0;
                            tx_next      = m_rdata_i;
                            state_next   = RDATA;
                        end
                    end
                end
                RDATA: begin
                    // Each fall presents the current MSB and then shifts, so the
                    // first fall after entry shows the captured word's MSB.
                    if (sclk_fall) begin
                        miso_next = tx_reg[MM_DATA_WIDTH-1];
                        tx_next   = {tx_reg[MM_DATA_WIDTH-2:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        bit_cnt_next = bit_cnt_inc;
                        if (bit_cnt_reg == LAST_WORD_BIT) begin
                            bit_cnt_next = '0;
                            state_next   = DONE;
                        end
                    end
                end
                WDATA: begin
                    if (sclk_rise) begin
                        rx_next      = rx_shifted;
                        bit_cnt_next = bit_cnt_inc;
                        if (bit_cnt_reg == LAST_WORD_BIT) begin
                            bit_cnt_next = '0;
                            wdata_next   = rx_shifted;
                            we_next      = 1'b1;
                            state_next   = DONE;
                        end
                    end
                end
                DONE, IGNORE: begin
                    // Wait for CS to rise; SCLK activity is ignored.
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign spi_miso_o    = (state_reg == RDATA) ? miso_reg : 1'b0;
    assign spi_miso_oe_o = armed_reg & ~cs_n_sync;
    assign m_addr_o      = addr_reg;
    assign m_wdata_o     = wdata_reg;
    assign m_we_o        = we_reg;
    assign frame_err_o   = err_reg;

endmodule

// File: doc/spi_mm_bridge.md
Name: spi_mm_bridge

Overview:
- SPI slave (mode 0, MSB first) that turns host SPI frames into single-word accesses on the memory-mapped master bus.
- Sits directly upstream of the MM interconnect. It drives m_addr/m_wdata/m_we and consumes m_rdata.
- The interconnect registers its read data, so rdata is valid 2 clk_sys cycles after an address change.
- All SPI inputs are oversampled in the clk_sys_i domain; no SCLK clock domain exists.

Parameters:
MM_ADDR_WIDTH, 8, address bus width; equals the address byte width.
MM_DATA_WIDTH, 16, data bus width; transferred as 2 bytes MSB first.
CMD_WRITE, 8'h02, write command byte.
CMD_READ, 8'h03, read command byte.

Ports:
clk_sys_i  in  1  system clock
rst_n_i  in  1  reset, asynchronous, active-low
spi_cs_n_i  in  1  chip select, active-low, asynchronous to clk_sys_i
spi_sclk_i  in  1  SPI clock, asynchronous
spi_mosi_i  in  1  host-to-slave data
spi_miso_o  out  1  slave-to-host data
spi_miso_oe_o  out  1  MISO output enable; tristate is at top level
m_addr_o  out  MM_ADDR_WIDTH  bus address
m_wdata_o  out  MM_DATA_WIDTH  bus write data
m_rdata_i  in  MM_DATA_WIDTH  bus read data (registered by interconnect)
m_we_o  out  1  write strobe, 1-cycle pulse
frame_err_o  out  1  1-cycle pulse on an aborted or invalid frame

Behaviour:
- Clock is clk_sys_i only. Reset is asynchronous, active-low on rst_n_i.
- Reset values: all outputs 0; FSM in IDLE; shift registers and counters cleared.
- Synchronisers: 2-FF sync on cs_n, sclk and mosi, plus a 3rd sclk stage for edge detect.
  - rise = sync high and previous low; fall = the converse.
  - MOSI is sampled on the rise cycle.
- Operating constraints:
  - SCLK high and low phases each >= 6 clk_sys cycles.
  - CS high between frames >= 4 cycles.
- Frame formats:
  - Write: CMD_WRITE, ADDR, DATA[15:8], DATA[7:0].
  - Read: CMD_READ, ADDR, DUMMY, 16 data bits out on MISO.
- FSM states: IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, DONE, IGNORE.
  - IDLE -> CMD when synced cs_n goes low. Bit counter cleared.
  - CMD: shift 8 bits. On the 8th rise, command == CMD_WRITE or CMD_READ -> ADDR; otherwise -> IGNORE with frame_err_o pulse.
  - ADDR: on the 8th rise, m_addr_o <= shifted byte (next cycle). Read -> DUMMY; write -> WDATA.
  - DUMMY: 8 bits, MOSI ignored. On the 8th rise, capture m_rdata_i into the tx shift register.
    - The capture is guaranteed >= 7 SCLK periods after the address update.
    - Next state RDATA.
  - RDATA: MISO presents tx[15] on the first fall after entry. Each subsequent fall shifts left. After the 16th rise -> DONE.
  - WDATA: shift 16 bits. On the 16th rise, next cycle: m_wdata_o <= word and m_we_o = 1 for exactly 1 cycle, same cycle. Then -> DONE.
  - DONE / IGNORE: further SCLK edges are ignored; MISO = 0; no bus activity.
  - Any state: synced cs_n high -> IDLE.
    - If the frame was incomplete (CMD, ADDR, DUMMY, WDATA or RDATA before its final bit), pulse frame_err_o for 1 cycle.
    - An incomplete write never asserts m_we_o.
- spi_miso_oe_o = synced cs_n low. spi_miso_o = 0 outside RDATA.
- m_addr_o and m_wdata_o hold their last values between frames; they change only on a completed ADDR byte or write.
- Only one bus access per frame; no auto-increment. A CS toggle between frames restarts cleanly.
- Reset asserted mid-frame: immediate return to reset values. No m_we_o pulse. After reset release with CS still low, stay in IDLE until CS goes high then low again.
- cs_n low at reset release must not start a frame; only a synced cs_n falling edge starts one.

Test Plan:
- Write 02,0E,A5,5A -> m_addr_o=0x0E; one m_we_o pulse with m_wdata_o=0xA55A; frame_err_o stays 0.
- Read 03,00,00 with m_rdata_i=0x1234 -> MISO bits 0x1234 MSB first; no m_we_o; m_addr_o=0x00 before the dummy byte ends.
- Write 02,10,FF then raise CS after 4 data bits -> no m_we_o; one frame_err_o pulse; m_wdata_o unchanged.
- Command 0x55 followed by 24 clocks -> no m_we_o; m_addr_o unchanged; MISO=0; frame_err_o pulses once at the 8th bit.
- Assert rst_n_i mid-WDATA, then release with CS low -> outputs 0; no write until the next full write frame 02,02,00,01 gives m_we_o with addr 0x02 and data 0x0001.
- Back-to-back frames: write 0x0E=0x0003, then read 0x0E (m_rdata_i fed back from a register model) -> MISO returns 0x0003.
